// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: MDU op codes and FSM state encoding shared with decoder and hazard unit
package mult_div_unit_pkg;

    localparam logic [2:0] MDU_NOP   = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// mult_div_unit_div_step: one restoring-division trial subtraction
module mult_div_unit_div_step #(
    parameter int NB_BITS = 32
) (
    input  logic [NB_BITS:0]   rem,
    input  logic [NB_BITS-1:0] divisor,
    output logic [NB_BITS-1:0] next_rem,
    output logic               q_bit
);

    logic [NB_BITS:0] diff;

    assign diff     = rem - {1'b0, divisor};
    assign q_bit    = ~diff[NB_BITS];
    assign next_rem = q_bit ? diff[NB_BITS-1:0] : rem[NB_BITS-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/DIV into HI/LO with MTHI/MTLO; MDU_FAST_MULT_EN makes multiplies single-cycle
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_OPE  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [NB_OPE-1:0]  i_mdu_op,
    input  logic [NB_BITS-1:0] i_data_a,
    input  logic [NB_BITS-1:0] i_data_b,
    input  logic               i_abort,
    output logic [NB_BITS-1:0] o_hi,
    output logic [NB_BITS-1:0] o_lo,
    output logic               o_busy
);

    localparam int NB_CNT = $clog2(NB_BITS);

    mdu_state_e           state;
    logic [NB_CNT-1:0]    cnt;
    logic [2*NB_BITS-1:0] acc;
    logic [NB_BITS-1:0]   opb;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 is_sgn;
    logic                 sign_a;
    logic                 sign_b;
    logic [NB_BITS-1:0]   abs_a;
    logic [NB_BITS-1:0]   abs_b;
    logic [NB_BITS:0]     mul_sum;
    logic [NB_BITS-1:0]   step_rem;
    logic                 step_q;
    logic [2*NB_BITS-1:0] acc_next;
    logic [2*NB_BITS-1:0] prod_fix;
    logic [NB_BITS-1:0]   quo_fix;
    logic [NB_BITS-1:0]   rem_fix;

    assign is_mul_op = i_mdu_op == NB_OPE'(MDU_MULT) || i_mdu_op == NB_OPE'(MDU_MULTU);
    assign is_div_op = i_mdu_op == NB_OPE'(MDU_DIV) || i_mdu_op == NB_OPE'(MDU_DIVU);
    assign is_sgn    = i_mdu_op == NB_OPE'(MDU_MULT) || i_mdu_op == NB_OPE'(MDU_DIV);
    assign sign_a    = is_sgn & i_data_a[NB_BITS-1];
    assign sign_b    = is_sgn & i_data_b[NB_BITS-1];
    assign abs_a     = sign_a ? -i_data_a : i_data_a;
    assign abs_b     = sign_b ? -i_data_b : i_data_b;

    // Shift-add multiply: low half of acc holds the unconsumed multiplier bits
    assign mul_sum = {1'b0, acc[2*NB_BITS-1:NB_BITS]} + (acc[0] ? {1'b0, opb} : '0);

    // Restoring divide: acc is {partial remainder, dividend bits shifting into quotient}
    mult_div_unit_div_step #(
        .NB_BITS (NB_BITS)
    ) u_div_step (
        .rem      (acc[2*NB_BITS-1:NB_BITS-1]),
        .divisor  (opb),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    assign acc_next = is_div ? {step_rem, acc[NB_BITS-2:0], step_q}
                             : {mul_sum, acc[NB_BITS-1:1]};

    // Divide by zero leaves |a| as remainder and all-ones quotient, so the
    // remainder sign fix restores the raw dividend and neg_q is held off.
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[NB_BITS-1:0] : acc[NB_BITS-1:0];
    assign rem_fix  = neg_r ? -acc[2*NB_BITS-1:NB_BITS] : acc[2*NB_BITS-1:NB_BITS];

`ifdef MDU_FAST_MULT_EN
    logic [2*NB_BITS-1:0] fast_prod;

    assign fast_prod = {{NB_BITS{sign_a}}, i_data_a} * {{NB_BITS{sign_b}}, i_data_b};
`endif

    // Control FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            o_hi   <= '0;
            o_lo   <= '0;
            o_busy <= 1'b0;
        end else if (i_abort) begin
            state  <= MDU_IDLE;
            o_busy <= 1'b0;
        end else if (state == MDU_IDLE) begin
            if (i_valid) begin
                if (i_mdu_op == NB_OPE'(MDU_MTHI)) begin
                    o_hi <= i_data_a;
                end else if (i_mdu_op == NB_OPE'(MDU_MTLO)) begin
                    o_lo <= i_data_a;
`ifdef MDU_FAST_MULT_EN
                end else if (is_mul_op) begin
                    {o_hi, o_lo} <= fast_prod;
`endif
                end else if (is_mul_op || is_div_op) begin
                    state  <= MDU_RUN;
                    o_busy <= 1'b1;
                    cnt    <= '0;
                    acc    <= {{NB_BITS{1'b0}}, abs_a};
                    opb    <= abs_b;
                    is_div <= is_div_op;
                    neg_q  <= (sign_a ^ sign_b) && (is_mul_op || i_data_b != '0);
                    neg_r  <= is_div_op && sign_a;
                end
            end
        end else if (state == MDU_RUN) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == NB_CNT'(NB_BITS - 1))
                state <= MDU_FIX;
        end else begin
            o_hi   <= is_div ? rem_fix : prod_fix[2*NB_BITS-1:NB_BITS];
            o_lo   <= is_div ? quo_fix : prod_fix[NB_BITS-1:0];
            state  <= MDU_IDLE;
            o_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit (honours MDU_FAST_MULT_EN)
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [2:0]  mdu_op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        abort;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int checks;
    int failures;

    mult_div_unit #(
        .NB_BITS (32),
        .NB_OPE  (3)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_mdu_op (mdu_op),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_abort  (abort),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid = 1'b1; mdu_op = op; data_a = a; data_b = b;
        @(posedge clk); #1;
        valid = 1'b0; mdu_op = MDU_NOP;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mult;
        logic [2:0]  ops [5] = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULT, MDU_MULTU};
        logic [31:0] va  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFD, 32'h80000000};
        logic [31:0] vb  [5] = '{32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000002};
        logic [31:0] eh  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        logic [31:0] el  [5] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFDD, 32'h0000000C, 32'h00000000};
        int n;
        for (int i = 0; i < 5; i++) begin
            start_op(ops[i], va[i], vb[i]);
            wait_idle(n);
            checks++; if (n !== MUL_LAT) begin failures++; $display("FAIL mult%0d_latency got=%0d exp=%0d", i, n, MUL_LAT); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL mult%0d_hi got=%h exp=%h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL mult%0d_lo got=%h exp=%h", i, lo, el[i]); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [6] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV, MDU_DIVU};
        logic [31:0] va  [6] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h00000007, 32'hFFFFFF9C, 32'hFFFFFFF9};
        logic [31:0] vb  [6] = '{32'h00000002, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000002};
        logic [31:0] eh  [6] = '{32'hFFFFFFFF, 32'd100, 32'h00000000, 32'h00000001, 32'hFFFFFF9C, 32'h00000001};
        logic [31:0] el  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC};
        int n;
        for (int i = 0; i < 6; i++) begin
            start_op(ops[i], va[i], vb[i]);
            wait_idle(n);
            checks++; if (n !== DIV_LAT) begin failures++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, n, DIV_LAT); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, el[i]); end
        end
    endtask

    task automatic test_back_to_back_mt;
        @(negedge clk);
        valid = 1'b1; mdu_op = MDU_MTHI; data_a = 32'h1234; data_b = 32'h0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        mdu_op = MDU_MTLO; data_a = 32'h5678;
        @(posedge clk); #1;
        valid = 1'b0; mdu_op = MDU_NOP;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mt_hi got=%h exp=%h", hi, 32'h1234); end
        checks++; if (lo !== 32'h5678) begin failures++; $display("FAIL mt_lo got=%h exp=%h", lo, 32'h5678); end
    endtask

    task automatic test_busy_ignore;
        int n;
        start_op(MDU_DIVU, 32'd1000, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        valid = 1'b1; mdu_op = MDU_DIVU; data_a = 32'd5; data_b = 32'd1;
        @(posedge clk); #1;
        valid = 1'b0; mdu_op = MDU_NOP;
        wait_idle(n);
        checks++; if (n + 6 !== DIV_LAT) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", n + 6, DIV_LAT); end
        checks++; if (hi !== 32'd6) begin failures++; $display("FAIL ignore_hi got=%h exp=%h", hi, 32'd6); end
        checks++; if (lo !== 32'd142) begin failures++; $display("FAIL ignore_lo got=%h exp=%h", lo, 32'd142); end
    endtask

    task automatic test_abort;
`ifdef MDU_FAST_MULT_EN
        logic [2:0] mid_op = MDU_DIVU;
`else
        logic [2:0] mid_op = MDU_MULT;
`endif
        start_op(MDU_MTHI, 32'hAAAA, 32'h0);
        start_op(MDU_MTLO, 32'hBBBB, 32'h0);
        start_op(mid_op, 32'd5, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_run_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'hAAAA) begin failures++; $display("FAIL abort_run_hi got=%h exp=%h", hi, 32'hAAAA); end
        checks++; if (lo !== 32'hBBBB) begin failures++; $display("FAIL abort_run_lo got=%h exp=%h", lo, 32'hBBBB); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
        start_op(MDU_DIVU, 32'd9, 32'd3);
        repeat (32) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_fix_pre_busy got=%b exp=1", busy); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_fix_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'hAAAA) begin failures++; $display("FAIL abort_fix_hi got=%h exp=%h", hi, 32'hAAAA); end
        checks++; if (lo !== 32'hBBBB) begin failures++; $display("FAIL abort_fix_lo got=%h exp=%h", lo, 32'hBBBB); end
        @(negedge clk);
        valid = 1'b1; mdu_op = MDU_MTHI; data_a = 32'hDEAD; abort = 1'b1;
        @(posedge clk); #1;
        mdu_op = MDU_DIV; data_a = 32'd8; data_b = 32'd2;
        @(posedge clk); #1;
        valid = 1'b0; abort = 1'b0; mdu_op = MDU_NOP;
        checks++; if (hi !== 32'hAAAA) begin failures++; $display("FAIL abort_accept_hi got=%h exp=%h", hi, 32'hAAAA); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_accept_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int n;
        start_op(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=%h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=%h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(MDU_DIVU, 32'd20, 32'd3);
        wait_idle(n);
        checks++; if (n !== DIV_LAT) begin failures++; $display("FAIL rst_recover_latency got=%0d exp=%0d", n, DIV_LAT); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL rst_recover_hi got=%h exp=%h", hi, 32'd2); end
        checks++; if (lo !== 32'd6) begin failures++; $display("FAIL rst_recover_lo got=%h exp=%h", lo, 32'd6); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; valid = 1'b0; mdu_op = MDU_NOP; data_a = '0; data_b = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_mult;
        test_div;
        test_back_to_back_mt;
        test_busy_ignore;
        test_abort;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
